uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO, configurable data width, optional parity and one or two stop bits. Next-generation transmit path of the SPART/UART block: sits between the bus-side write interface and the serial `txd` pin, paced by the baud-rate generator's one-cycle `baud_t_enable` tick. Unlike the single-register transmitter, it buffers several characters and aligns every bit, including the start bit, to baud ticks.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: every bit, start bit included, is aligned
// to baud ticks, and queued characters go out back-to-back with no idle bit.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_t_enable,
    input  logic                 data_t_enable,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 txd,
    output logic                 tbr,
    output logic                 tx_busy,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_nxt;
    logic                 push, pop, start;

    logic [2:0]           state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 par_bit, par_bit_nxt;
    logic                 par_en_l, par_en_nxt;
    logic                 two_stop_l, two_stop_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 txd_nxt;

    // tbr is registered, so a write while full is dropped even if a pop coincides
    assign push = data_t_enable && tbr;

    // Next-state and next-output logic; nothing moves except on a baud tick
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        par_bit_nxt  = par_bit;
        par_en_nxt   = par_en_l;
        two_stop_nxt = two_stop_l;
        stop_cnt_nxt = stop_cnt;
        txd_nxt      = txd;
        start        = 1'b0;
        pop          = 1'b0;
        if (baud_t_enable) begin
            case (state)
                S_IDLE: begin
                    txd_nxt = 1'b1;
                    if (fifo_count != '0) start = 1'b1;
                end
                S_START: begin
                    state_nxt   = S_DATA;
                    txd_nxt     = shift_q[0];
                    shift_nxt   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_nxt = '0;
                end
                S_DATA: begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        stop_cnt_nxt = 1'b0;
                        if (par_en_l) begin
                            state_nxt = S_PARITY;
                            txd_nxt   = par_bit;
                        end else begin
                            state_nxt = S_STOP;
                            txd_nxt   = 1'b1;
                        end
                    end else begin
                        txd_nxt     = shift_q[0];
                        shift_nxt   = {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
                S_PARITY: begin
                    state_nxt    = S_STOP;
                    txd_nxt      = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
                S_STOP: begin
                    txd_nxt = 1'b1;
                    if (two_stop_l && !stop_cnt) begin
                        stop_cnt_nxt = 1'b1;
                    end else if (fifo_count != '0) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    txd_nxt   = 1'b1;
                end
            endcase
        end
        // Frame start: pop head, latch config, drive the start bit
        if (start) begin
            pop          = 1'b1;
            state_nxt    = S_START;
            shift_nxt    = mem[rd_ptr];
            par_bit_nxt  = (^mem[rd_ptr]) ^ parity_odd;
            par_en_nxt   = parity_en;
            two_stop_nxt = two_stop;
            txd_nxt      = 1'b0;
        end
        count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            par_en_l   <= 1'b0;
            two_stop_l <= 1'b0;
            stop_cnt   <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tbr        <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            par_bit    <= par_bit_nxt;
            par_en_l   <= par_en_nxt;
            two_stop_l <= two_stop_nxt;
            stop_cnt   <= stop_cnt_nxt;
            txd        <= txd_nxt;
            tx_busy    <= (state_nxt != S_IDLE);
            wr_ptr     <= wr_ptr + PTR_W'(push);
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            fifo_count <= count_nxt;
            tbr        <= (count_nxt != CNT_W'(FIFO_DEPTH));
            overflow   <= overflow | (data_t_enable & ~tbr);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

endmodule
